uart_rx_async: RTL and testbench

//  Asynchronous UART receiver; companion of the Tx_async transmitter in CoreUART/CoreUARTapb.

---
 rtl/uart_rx_async.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_async.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_async.sv
// uart_rx_async: asynchronous UART receiver for the CoreUART register block.
// Oversamples rx with a 16x baud enable, assembles 7/8-bit frames with optional
// parity, then either holds the byte (rx_rdy) or strobes it into an RX FIFO.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority
// sampling at ticks 7/8/9 instead of a single sample at tick 8.
module uart_rx_async #(
  parameter int RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_rx
);

  typedef enum logic [2:0] {
    rx_idle      = 3'd0,
    start_bit    = 3'd1,
    rx_data_bits = 3'd2,
    parity_bit   = 3'd3,
    rx_stop_bit  = 3'd4
  } rx_state_t;

  rx_state_t  state_r, next_state_s;
  logic       rx_meta_r, rx_sync_r;
  logic [3:0] samp_cnt_r, bit_cnt_r;
  logic [7:0] shift_r, frame_data_r;
  logic       par_acc_r, perr_r, stop_r, done_r, wait_high_r;
  logic       decide_s, bit_s, start_s, last_bit_s;
  logic [7:0] rx_byte_r;
  logic       rx_rdy_r, parity_err_r, framing_err_r, overflow_r, fifo_write_rx_r;

  // Parity check result: 1 means the received parity bit is wrong
  function automatic logic par_check(input logic acc, input logic pbit, input logic odd);
    return acc ^ pbit ^ odd;
  endfunction

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote7_r, vote8_r;

  // 2-of-3 majority of the three samples around the bit centre
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two early votes of the majority window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vote7_r <= 1'b1;
      vote8_r <= 1'b1;
    end else if (baud_clock && (samp_cnt_r == 4'd7)) begin
      vote7_r <= rx_sync_r;
    end else if (baud_clock && (samp_cnt_r == 4'd8)) begin
      vote8_r <= rx_sync_r;
    end
  end

  assign decide_s = baud_clock && (samp_cnt_r == 4'd9);
  assign bit_s    = maj3(vote7_r, vote8_r, rx_sync_r);
`else
  assign decide_s = baud_clock && (samp_cnt_r == 4'd8);
  assign bit_s    = rx_sync_r;
`endif

  // A new start is only accepted once the line has been seen high after a break
  assign start_s    = baud_clock && !rx_sync_r && !wait_high_r;
  // >= rather than == so a mid-frame bit8 change cannot strand the counter
  assign last_bit_s = (bit_cnt_r >= (bit8 ? 4'd7 : 4'd6));

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= rx_idle;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      rx_idle: begin
        if (start_s) next_state_s = start_bit;
        else         next_state_s = rx_idle;
      end
      start_bit: begin
        if (decide_s) next_state_s = bit_s ? rx_idle : rx_data_bits;
        else          next_state_s = start_bit;
      end
      rx_data_bits: begin
        if (decide_s && last_bit_s) next_state_s = parity_en ? parity_bit : rx_stop_bit;
        else                        next_state_s = rx_data_bits;
      end
      parity_bit: begin
        if (decide_s) next_state_s = rx_stop_bit;
        else          next_state_s = parity_bit;
      end
      rx_stop_bit: begin
        // Return at the stop-bit centre so a back-to-back start edge is not missed
        if (decide_s) next_state_s = rx_idle;
        else          next_state_s = rx_stop_bit;
      end
      default: next_state_s = rx_idle;
    endcase
  end

  // Sample counter, shift register, parity accumulator and frame capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_cnt_r   <= 4'd0;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      frame_data_r <= 8'h00;
      par_acc_r    <= 1'b0;
      perr_r       <= 1'b0;
      stop_r       <= 1'b1;
      done_r       <= 1'b0;
      wait_high_r  <= 1'b0;
    end else begin
      if ((state_r == rx_idle) && start_s) samp_cnt_r <= 4'd0;
      else if (baud_clock)                 samp_cnt_r <= samp_cnt_r + 4'd1;
      done_r <= 1'b0;
      case (state_r)
        rx_idle: begin
          if (rx_sync_r) wait_high_r <= 1'b0;
          if (start_s) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            par_acc_r <= 1'b0;
            perr_r    <= 1'b0;
          end
        end
        rx_data_bits: begin
          if (decide_s) begin
            shift_r   <= {bit_s, shift_r[7:1]};
            par_acc_r <= par_acc_r ^ bit_s;
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        parity_bit: begin
          if (decide_s) perr_r <= par_check(par_acc_r, bit_s, odd_n_even);
        end
        rx_stop_bit: begin
          if (decide_s) begin
            done_r       <= 1'b1;
            stop_r       <= bit_s;
            wait_high_r  <= ~bit_s;
            // 7-bit frames land in [7:1]; right-align with bit7 cleared
            frame_data_r <= bit8 ? shift_r : {1'b0, shift_r[7:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Host-visible result registers, updated one clk after the stop decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte_r       <= 8'h00;
      rx_rdy_r        <= 1'b0;
      parity_err_r    <= 1'b0;
      framing_err_r   <= 1'b0;
      overflow_r      <= 1'b0;
      fifo_write_rx_r <= 1'b1;
    end else begin
      fifo_write_rx_r <= 1'b1;
      if (read_rx_byte) begin
        rx_rdy_r   <= 1'b0;
        overflow_r <= 1'b0;
      end
      if (done_r) begin
        parity_err_r  <= perr_r & parity_en;
        framing_err_r <= ~stop_r;
        if (RX_FIFO == 0) begin
          // A read in the same clk frees the holding register for the new byte
          if (!rx_rdy_r || read_rx_byte) begin
            rx_byte_r <= frame_data_r;
            rx_rdy_r  <= 1'b1;
          end else begin
            overflow_r <= 1'b1;
          end
        end else begin
          if (!fifo_full) begin
            rx_byte_r       <= frame_data_r;
            fifo_write_rx_r <= 1'b0;
          end else begin
            overflow_r <= 1'b1;
          end
        end
      end
    end
  end

  assign rx_byte       = rx_byte_r;
  assign rx_rdy        = rx_rdy_r;
  assign parity_err    = parity_err_r;
  assign framing_err   = framing_err_r;
  assign overflow      = overflow_r;
  assign fifo_write_rx = fifo_write_rx_r;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: one holding-register instance and one
// FIFO-mode instance share the serial line. Baud tick every 4 clks, so one
// bit lasts 64 clks.
module tb_uart_rx_async;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       rd0 = 1'b0;
  logic       rd1 = 1'b0;
  logic       full0 = 1'b0;
  logic       full1 = 1'b0;
  logic [7:0] byte0, byte1;
  logic       rdy0, rdy1, perr0, perr1, ferr0, ferr1, ovf0, ovf1, wr0, wr1;

  int errors = 0;
  int checks = 0;
  int strobes0 = 0;
  int strobes1 = 0;
  int snap;

  uart_rx_async #(.RX_FIFO(0)) u0 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(rd0), .fifo_full(full0), .rx_byte(byte0), .rx_rdy(rdy0),
    .parity_err(perr0), .framing_err(ferr0), .overflow(ovf0), .fifo_write_rx(wr0)
  );

  uart_rx_async #(.RX_FIFO(1)) u1 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(rd1), .fifo_full(full1), .rx_byte(byte1), .rx_rdy(rdy1),
    .parity_err(perr1), .framing_err(ferr1), .overflow(ovf1), .fifo_write_rx(wr1)
  );

  always #5 clk = ~clk;

  // 16x baud enable: one-clk pulse every 4 clks
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
    end
  end

  // Count clks during which each FIFO write strobe is low
  always @(negedge clk) begin
    if (wr0 === 1'b0) strobes0++;
    if (wr1 === 1'b0) strobes1++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(stop);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic read0();
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic read1();
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (4) @(negedge clk);
    check("reset rx_byte", byte0, 8'h00);
    check("reset rx_rdy", rdy0, 8'h00);
    check("reset parity_err", perr0, 8'h00);
    check("reset framing_err", ferr0, 8'h00);
    check("reset overflow", ovf0, 8'h00);
    check("reset fifo_write_rx", wr1, 8'h01);
    reset_n = 1'b1;
    repeat (64) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("8N1 A5 rx_byte", byte0, 8'hA5);
    check("8N1 A5 rx_rdy", rdy0, 8'h01);
    check("8N1 A5 parity_err", perr0, 8'h00);
    check("8N1 A5 framing_err", ferr0, 8'h00);
    check("8N1 A5 overflow", ovf0, 8'h00);
    read0();
    check("read clears rx_rdy", rdy0, 8'h00);

    // 7E1 0x35: four ones, so even parity bit 0 is correct and 1 is wrong
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
    check("7E1 35 good rx_byte", byte0, 8'h35);
    check("7E1 35 good parity_err", perr0, 8'h00);
    read0();
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    check("7E1 35 bad rx_byte", byte0, 8'h35);
    check("7E1 35 bad parity_err", perr0, 8'h01);
    read0();

    // 8O1 0xA5: four ones, odd parity bit 1 is correct
    bit8 = 1'b1; odd_n_even = 1'b1;
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    check("8O1 A5 rx_byte", byte0, 8'hA5);
    check("8O1 A5 parity_err", perr0, 8'h00);
    read0();
    parity_en = 1'b0; odd_n_even = 1'b0;

    // 4-tick (16 clk) start glitch is rejected
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch rx_rdy", rdy0, 8'h00);
    check("glitch framing_err", ferr0, 8'h00);
    check("glitch overflow", ovf0, 8'h00);

    // 0x3C with stop bit 0, then a clean 0x01
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check("break 3C rx_byte", byte0, 8'h3C);
    check("break 3C framing_err", ferr0, 8'h01);
    check("break 3C rx_rdy", rdy0, 8'h01);
    read0();
    repeat (64) @(negedge clk);
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    check("after break 01 rx_byte", byte0, 8'h01);
    check("after break 01 framing_err", ferr0, 8'h00);
    read0();

    // Overflow: 0x11 then 0x22 with no read
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("overflow rx_byte kept", byte0, 8'h11);
    check("overflow flag", ovf0, 8'h01);
    check("overflow rx_rdy", rdy0, 8'h01);
    read0();
    check("overflow read rx_rdy", rdy0, 8'h00);
    check("overflow read clears", ovf0, 8'h00);

    // FIFO mode: one-clk strobe, then fifo_full drops the byte
    snap = strobes1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("fifo 5A rx_byte", byte1, 8'h5A);
    check("fifo 5A strobe clks", 8'(strobes1 - snap), 8'h01);
    check("fifo rx_rdy held 0", rdy1, 8'h00);
    check("fifo 5A overflow", ovf1, 8'h00);
    read0();
    full1 = 1'b1;
    snap = strobes1;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
    check("fifo full strobe clks", 8'(strobes1 - snap), 8'h00);
    check("fifo full overflow", ovf1, 8'h01);
    check("fifo full rx_byte kept", byte1, 8'h5A);
    check("hold 77 rx_rdy", rdy0, 8'h01);
    full1 = 1'b0;

    // Reset mid-frame after 3 data bits of 0xC3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset rx_byte", byte0, 8'h00);
    check("midreset rx_rdy", rdy0, 8'h00);
    check("midreset fifo overflow", ovf1, 8'h00);
    check("midreset fifo rx_byte", byte1, 8'h00);
    check("midreset fifo_write_rx", wr1, 8'h01);
    rx = 1'b1;
    reset_n = 1'b1;
    repeat (128) @(negedge clk);
    snap = strobes1;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    check("post-reset C3 rx_byte", byte0, 8'hC3);
    check("post-reset C3 rx_rdy", rdy0, 8'h01);
    check("post-reset C3 framing_err", ferr0, 8'h00);
    check("post-reset fifo C3 rx_byte", byte1, 8'hC3);
    check("post-reset fifo C3 strobe clks", 8'(strobes1 - snap), 8'h01);
    check("holding mode never strobes", 8'(strobes0), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
